// File: rtl/alu_pipe_if.sv
// alu_pipe_if: operand/result handshake bundle for alu_pipe
interface alu_pipe_if #(parameter int BITS = 8, parameter int CNT_W = 8);
  logic [BITS-1:0] i_a;
  logic [BITS-1:0] i_b;
  logic [2:0] i_op;
  logic i_valid;
  logic o_ready;
  logic [BITS-1:0] o_out;
  logic [3:0] o_status;
  logic o_valid;
  logic i_ready;
  logic [CNT_W-1:0] o_err_cnt;
  modport slave (input i_a, i_b, i_op, i_valid, i_ready, output o_ready, o_out, o_status, o_valid, o_err_cnt);
  modport master (output i_a, i_b, i_op, i_valid, i_ready, input o_ready, o_out, o_status, o_valid, o_err_cnt);
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage valid/ready 8-op ALU with status flags and saturating error count
module alu_pipe #(
  parameter int BITS = 8,
  parameter int CNT_W = 8
) (
  input logic i_clk,
  input logic i_rst,
  alu_pipe_if.slave bus
);
  localparam logic [2:0] OP_SUB = 3'd0;
  localparam logic [2:0] OP_CMP = 3'd1;
  localparam logic [2:0] OP_SHL = 3'd2;
  localparam logic [2:0] OP_CHG = 3'd3;
  localparam logic [2:0] OP_ADD = 3'd4;
  localparam logic [2:0] OP_AND = 3'd5;
  localparam logic [2:0] OP_OR = 3'd6;
  logic s1_v, s2_v, s1_adv, take, oor, ovf, err;
  logic [BITS-1:0] s1_a, s1_b, s2_out, res;
  logic [2:0] s1_op;
  logic [3:0] s2_st, st;
  logic [CNT_W-1:0] cnt;
  logic [BITS:0] sum, dif;
  logic [2*BITS-1:0] shl;
  logic [BITS+2:0] cmp;
  assign s1_adv = s1_v && (!s2_v || bus.i_ready);
  assign bus.o_ready = !s1_v || s1_adv;
  assign take = bus.i_valid && bus.o_ready;
  assign bus.o_valid = s2_v;
  assign bus.o_out = s2_out;
  assign bus.o_status = s2_st;
  assign bus.o_err_cnt = cnt;
  always_comb begin
    oor = s1_b >= BITS'(BITS);
    sum = {1'b0, s1_a} + {1'b0, s1_b};
    dif = {1'b0, s1_a} - {1'b0, s1_b};
    shl = {{BITS{1'b0}}, s1_a} << s1_b;
    cmp = (BITS+3)'({s1_a < s1_b, s1_a == s1_b, s1_a > s1_b});
    err = oor && (s1_op == OP_SHL || s1_op == OP_CHG);
    res = err ? '0 :
          s1_op == OP_SUB ? dif[BITS-1:0] :
          s1_op == OP_CMP ? cmp[BITS-1:0] :
          s1_op == OP_SHL ? shl[BITS-1:0] :
          s1_op == OP_CHG ? s1_a ^ (BITS'(1) << s1_b) :
          s1_op == OP_ADD ? sum[BITS-1:0] :
          s1_op == OP_AND ? s1_a & s1_b :
          s1_op == OP_OR ? s1_a | s1_b : s1_a ^ s1_b;
    ovf = s1_op == OP_SUB ? dif[BITS] :
          s1_op == OP_ADD ? sum[BITS] :
          s1_op == OP_SHL ? !oor && |shl[2*BITS-1:BITS] : 1'b0;
    // EVEN tracks the parity of zero bits, hence the inversion before reducing
    st = {$countones(res) == 1, ovf, ~^(~res), err};
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      s2_out <= '0;
      s2_st <= '0;
      cnt <= '0;
    end else begin
      if (take) begin
        s1_a <= bus.i_a;
        s1_b <= bus.i_b;
        s1_op <= bus.i_op;
      end
      s1_v <= take || (s1_v && !s1_adv);
      if (s1_adv) begin
        s2_out <= res;
        s2_st <= st;
      end
      s2_v <= s1_adv || (s2_v && !bus.i_ready);
      if (s2_v && bus.i_ready && s2_st[0] && cnt != '1) cnt <= cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed vectors, stall/reset sequences and a scoreboarded random stream
module tb_alu_pipe;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  alu_pipe_if #(.BITS(8), .CNT_W(8)) bus ();
  alu_pipe_if #(.BITS(8), .CNT_W(2)) bus2 ();
  alu_pipe #(.BITS(8), .CNT_W(8)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));
  alu_pipe #(.BITS(8), .CNT_W(2)) dut2 (.i_clk(clk), .i_rst(rst), .bus(bus2));
  typedef struct { logic [7:0] out; logic [3:0] st; } res_t;
  typedef struct { logic [7:0] a; logic [7:0] b; logic [2:0] op; logic [7:0] out; logic [3:0] st; int cnt; } vec_t;
  int total = 0;
  int bad = 0;
  int cnt_m = 0;
  int n_out = 0;
  logic mon_on = 1'b0;
  logic hold_v = 1'b0;
  res_t held;
  res_t exp_q[$];
  int got_q[$];
  vec_t tbl[15];
  task automatic chk(input string nm, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask
  // reference computed from the operation rules with plain integer arithmetic
  function automatic res_t model(input int a, input int b, input int op);
    res_t r;
    int o = 0, ovf = 0, err = 0, n = 0;
    case (op)
      0: begin o = (a - b + 256) % 256; ovf = int'(a < b); end
      1: o = int'(a > b) + 2 * int'(a == b) + 4 * int'(a < b);
      2: if (b >= 8) err = 1; else begin o = a * (1 << b); ovf = int'(o > 255); o = o % 256; end
      3: if (b >= 8) err = 1; else o = ((a >> b) & 1) != 0 ? a - (1 << b) : a + (1 << b);
      4: begin o = a + b; ovf = int'(o > 255); o = o % 256; end
      5: o = a & b;
      6: o = a | b;
      default: o = a ^ b;
    endcase
    for (int i = 0; i < 8; i++) n += (o >> i) & 1;
    r.out = 8'(o);
    r.st = {n == 1, ovf != 0, (8 - n) % 2 == 0, err != 0};
    return r;
  endfunction
  always @(negedge clk) begin
    if (mon_on) begin
      res_t e;
      chk("err_cnt", int'(bus.o_err_cnt), cnt_m);
      if (hold_v && bus.o_valid) begin
        chk("stall_out_stable", int'(bus.o_out), int'(held.out));
        chk("stall_st_stable", int'(bus.o_status), int'(held.st));
      end
      if (bus.o_valid && bus.i_ready) begin
        n_out++;
        got_q.push_back(int'(bus.o_out));
        if (exp_q.size() == 0) chk("extra_beat", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("out", int'(bus.o_out), int'(e.out));
          chk("status", int'(bus.o_status), int'(e.st));
          if (e.st[0] && cnt_m != 255) cnt_m++;
        end
      end
      hold_v = bus.o_valid && !bus.i_ready;
      held.out = bus.o_out;
      held.st = bus.o_status;
      if (bus.i_valid && bus.o_ready) exp_q.push_back(model(int'(bus.i_a), int'(bus.i_b), int'(bus.i_op)));
    end else hold_v = 1'b0;
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    bus.i_valid = 1'b0;
    rst = 1'b0;
    step();
    rst = 1'b1;
    cnt_m = 0;
    n_out = 0;
    exp_q.delete();
    got_q.delete();
  endtask
  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    bus.i_a = a;
    bus.i_b = b;
    bus.i_op = op;
    bus.i_valid = 1'b1;
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
  initial begin
    int k;
    logic saw;
    tbl[0] = '{8'h05, 8'h07, 3'd0, 8'hFE, 4'b0100, 0};
    tbl[1] = '{8'h81, 8'h01, 3'd2, 8'h02, 4'b1100, 0};
    tbl[2] = '{8'h00, 8'h09, 3'd3, 8'h00, 4'b0011, 1};
    tbl[3] = '{8'h03, 8'h03, 3'd1, 8'h02, 4'b1000, 1};
    tbl[4] = '{8'hFF, 8'h01, 3'd4, 8'h00, 4'b0110, 1};
    tbl[5] = '{8'hF0, 8'h3C, 3'd5, 8'h30, 4'b0010, 1};
    tbl[6] = '{8'h01, 8'h00, 3'd6, 8'h01, 4'b1000, 1};
    tbl[7] = '{8'hFF, 8'h00, 3'd7, 8'hFF, 4'b0010, 1};
    tbl[8] = '{8'h03, 8'h07, 3'd2, 8'h80, 4'b1100, 1};
    tbl[9] = '{8'h01, 8'h08, 3'd2, 8'h00, 4'b0011, 2};
    tbl[10] = '{8'h0F, 8'h03, 3'd3, 8'h07, 4'b0000, 2};
    tbl[11] = '{8'h07, 8'h05, 3'd0, 8'h02, 4'b1000, 2};
    tbl[12] = '{8'h09, 8'h03, 3'd1, 8'h01, 4'b1000, 2};
    tbl[13] = '{8'h01, 8'hC8, 3'd1, 8'h04, 4'b1000, 2};
    tbl[14] = '{8'h80, 8'h80, 3'd4, 8'h00, 4'b0110, 2};
    bus.i_a = '0; bus.i_b = '0; bus.i_op = '0; bus.i_valid = 1'b0; bus.i_ready = 1'b1;
    bus2.i_a = '0; bus2.i_b = '0; bus2.i_op = '0; bus2.i_valid = 1'b0; bus2.i_ready = 1'b1;
    step();
    do_reset();
    chk("rst_valid", int'(bus.o_valid), 0);
    chk("rst_out", int'(bus.o_out), 0);
    chk("rst_status", int'(bus.o_status), 0);
    chk("rst_cnt", int'(bus.o_err_cnt), 0);
    chk("rst_ready", int'(bus.o_ready), 1);
    foreach (tbl[i]) begin
      drive(tbl[i].a, tbl[i].b, tbl[i].op);
      step();
      bus.i_valid = 1'b0;
      step();
      chk($sformatf("vec%0d_valid", i), int'(bus.o_valid), 1);
      chk($sformatf("vec%0d_out", i), int'(bus.o_out), int'(tbl[i].out));
      chk($sformatf("vec%0d_status", i), int'(bus.o_status), int'(tbl[i].st));
      step();
      chk($sformatf("vec%0d_cnt", i), int'(bus.o_err_cnt), tbl[i].cnt);
      chk($sformatf("vec%0d_drained", i), int'(bus.o_valid), 0);
    end
    do_reset();
    mon_on = 1'b1;
    k = 0;
    saw = 1'b0;
    for (int c = 0; c < 40 && n_out < 6; c++) begin
      bus.i_ready = !(c >= 3 && c <= 5);
      bus.i_a = 8'(k);
      bus.i_b = 8'd1;
      bus.i_op = 3'd4;
      bus.i_valid = k < 6;
      #1;
      if (!bus.o_ready) saw = 1'b1;
      if (bus.i_valid && bus.o_ready) k++;
      step();
    end
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    chk("stall_beats", n_out, 6);
    chk("stall_ready_fell", int'(saw), 1);
    chk("stall_count", got_q.size(), 6);
    for (int j = 0; j < got_q.size() && j < 6; j++) chk($sformatf("stall_res%0d", j), got_q[j], j + 1);
    chk("stall_left", exp_q.size(), 0);
    for (int c = 0; c < 400; c++) begin
      bus.i_a = 8'($urandom);
      bus.i_b = $urandom_range(0, 1) != 0 ? 8'($urandom) : 8'($urandom_range(0, 9));
      bus.i_op = 3'($urandom);
      bus.i_valid = $urandom_range(0, 3) != 0;
      bus.i_ready = $urandom_range(0, 9) < 7;
      step();
    end
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    for (int c = 0; c < 10; c++) step();
    chk("rand_drain", exp_q.size(), 0);
    chk("rand_some_beats", int'(n_out > 100), 1);
    mon_on = 1'b0;
    step();
    bus.i_ready = 1'b0;
    drive(8'h01, 8'h01, 3'd4);
    step();
    drive(8'h02, 8'h02, 3'd4);
    step();
    bus.i_valid = 1'b0;
    chk("flight_valid", int'(bus.o_valid), 1);
    chk("flight_full", int'(bus.o_ready), 0);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("frst_valid", int'(bus.o_valid), 0);
    chk("frst_out", int'(bus.o_out), 0);
    chk("frst_cnt", int'(bus.o_err_cnt), 0);
    chk("frst_ready", int'(bus.o_ready), 1);
    bus.i_ready = 1'b1;
    drive(8'h05, 8'h07, 3'd0);
    step();
    bus.i_valid = 1'b0;
    chk("post_rst_lat1", int'(bus.o_valid), 0);
    step();
    chk("post_rst_valid", int'(bus.o_valid), 1);
    chk("post_rst_out", int'(bus.o_out), 8'hFE);
    chk("post_rst_status", int'(bus.o_status), 4'b0100);
    step();
    for (int c = 0; c < 7; c++) begin
      bus2.i_a = 8'h00;
      bus2.i_b = 8'd8;
      bus2.i_op = 3'd3;
      bus2.i_valid = c < 5;
      step();
      if (c >= 2) chk($sformatf("sat_cnt%0d", c - 2), int'(bus2.o_err_cnt), c - 1 > 3 ? 3 : c - 1);
    end
    bus2.i_valid = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, pipelined successor to the 4-op ALU.
- Eight operations selected by a 3-bit opcode, with a valid/ready handshake on input and output, so back-to-back operations stream without loss under backpressure.
- Produces a 4-bit status vector per result and a saturating count of errored operations.
- Sits between the operand source (register file / test driver) and the result consumer.

Parameters:
BITS, 8, operand/result width (>=2)
CNT_W, 8, width of error counter

Ports:
i_clk  in  1  clock, all logic on rising edge
i_rst  in  1  synchronous, active-low reset
i_a  in  BITS  operand A (unsigned)
i_b  in  BITS  operand B (unsigned; shift amount / bit index for SHL, CHG)
i_op  in  3  opcode
i_valid  in  1  input beat valid
o_ready  out  1  block can accept input this cycle
o_out  out  BITS  result
o_status  out  4  {SINGLE, OVF, EVEN, ERROR} = bits [3:0] as [3]=SINGLE [2]=OVF [1]=EVEN [0]=ERROR
o_valid  out  1  result beat valid
i_ready  in  1  consumer accepts result
o_err_cnt  out  CNT_W  count of completed beats with ERROR=1, saturating

Behaviour:
- Reset (i_rst=0 at a rising edge): both pipeline stages invalid; o_valid=0, o_out=0, o_status=0, o_err_cnt=0. o_ready=1 in the first cycle after reset. In-flight beats are dropped.
- Input handshake: a beat is accepted on a rising edge with i_valid=1 and o_ready=1. Output handshake: a beat is consumed on a rising edge with o_valid=1 and i_ready=1.
- Pipeline, 2 registered stages:
  - S1 captures a, b and op.
  - S2 captures the computed result and status.
  - Latency is 2 cycles from acceptance to o_valid when unstalled. Throughput is 1 beat per cycle.
- Stall rules:
  - S2 holds when o_valid=1 and i_ready=0.
  - S1 advances into S2 when S2 is empty or being consumed.
  - o_ready = !S1_valid || S1 advancing. This is combinational from i_ready and state.
  - The block holds at most 2 beats. No beat is lost or duplicated.
  - o_out and o_status are stable while o_valid=1 and i_ready=0.
- Operations (widths BITS; result truncated to BITS):
  - 000 SUB: a-b. OVF = borrow (a<b).
  - 001 CMP: out[0]=(a>b), out[1]=(a==b), out[2]=(a<b), other bits 0. OVF=0.
  - 010 SHL: a<<b. If b>=BITS: out=0, ERROR=1, OVF=0. Otherwise OVF=1 if any 1 bit is shifted out.
  - 011 CHG: a with bit b inverted. If b>=BITS: out=0, ERROR=1.
  - 100 ADD: a+b. OVF = carry out.
  - 101 AND, 110 OR, 111 XOR: bitwise. OVF=0.
  - ERROR=0 for all ops except the SHL/CHG range cases.
- Status derived from the final out:
  - EVEN = 1 when the count of 0 bits in out is even (0 zeros counts as even).
  - SINGLE = 1 when exactly one bit of out is 1.
- Error counter:
  - Increments by 1 on each output handshake whose ERROR=1.
  - Holds at 2^CNT_W-1 (no wrap).
  - Not cleared except by reset.
- Simultaneous accept into S1 and consume from S2 in the same cycle is legal and keeps full throughput.
- Inputs are ignored when i_valid=0; opcode and operand values of non-accepted cycles have no effect.

Test Plan:
- BITS=8, SUB a=5 b=7, i_ready=1 -> 2 cycles later o_valid=1, o_out=0xFE, o_status=4'b0100.
- SHL a=0x81 b=1 -> o_out=0x02, o_status=4'b1100. Then CHG a=0x00 b=9 -> o_out=0x00, o_status=4'b0011, o_err_cnt=1.
- CMP a=3 b=3 -> o_out=0x02, o_status=4'b1000. ADD a=0xFF b=0x01 -> o_out=0x00, o_status=4'b0110.
- Stream of 6 ADDs a=k, b=1 (k=0..5), with i_ready=0 for cycles 3-5 -> o_ready falls after 2 beats are buffered; results 1..6 are delivered in order, none lost or duplicated, and o_out is stable while stalled.
- CNT_W=2, 5 consecutive CHG beats with b=8 -> o_err_cnt sequence 1,2,3,3,3.
- Reset asserted for 1 cycle with 2 beats in flight -> next cycle o_valid=0, o_out=0, o_err_cnt=0, o_ready=1. A new beat afterwards returns its correct result after 2 cycles.
